// File: rtl/rom_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Holds the FSM state encoding, byte-lane constants and the header length check.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int unsigned BYTE_LANES   = 4;
  localparam int unsigned HEADER_BYTES = 2;
  localparam int unsigned LANE_IDX_W   = $clog2(BYTE_LANES);

  // A load must be non-empty and fit the memory; 32-bit math keeps 2^ADDR_WIDTH exact.
  function automatic logic length_valid(input logic [15:0] len, input int unsigned addr_width);
    return (len != 16'd0) && ({16'd0, len} <= (32'd1 << addr_width));
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream handshake and instruction-memory write port bundles.
// Signal names match the original flat port list of rom_loader.
interface rom_loader_byte_if;
  logic [7:0] BYTE_IN;
  logic       BYTE_VALID;
  logic       BYTE_READY;

  modport master (output BYTE_IN, output BYTE_VALID, input  BYTE_READY);
  modport slave  (input  BYTE_IN, input  BYTE_VALID, output BYTE_READY);
endinterface

interface rom_loader_mem_if #(parameter int unsigned ADDR_WIDTH = 10);
  logic                  WRITE_ENABLE;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  logic [31:0]           DATA_OUT;

  modport master (output WRITE_ENABLE, output ADDRESS, output DATA_OUT);
  modport slave  (input  WRITE_ENABLE, input  ADDRESS, input  DATA_OUT);
endinterface

// File: rtl/rom_loader_word_assembler.sv
// Little-endian word assembly: a lane index plus a 32-bit register filled one byte per shift.
// word_next already contains the incoming byte so the caller can capture a full word on the 4th shift.
module loader_word_assembler
  import rom_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        full
);

  logic [LANE_IDX_W-1:0] idx_q;
  logic [31:0]           word_q;

  always_comb begin
    word_next = word_q;
    word_next[idx_q*8 +: 8] = byte_in;
  end

  assign full = (idx_q == LANE_IDX_W'(BYTE_LANES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (shift_in) begin
      idx_q  <= idx_q + 1'b1;
      word_q <= word_next;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Program loader: length-prefixed byte stream in, one instruction-memory write per 32-bit word out.
// BUSY covers the whole load so the core can be held in reset meanwhile.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  rom_loader_byte_if.slave  byte_bus,
  rom_loader_mem_if.master  mem_bus,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q;
  logic [CNT_W-1:0]      last_addr_q;
  logic [CNT_W-1:0]      word_addr_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [31:0]           data_q;
  logic                  done_q;

  logic        byte_ready, xfer;
  logic [15:0] hdr_len;
  logic        hdr_ok, is_last;
  logic        start_load, len_lo_load, len_hi_load;
  logic        asm_shift, word_capture, addr_incr, done_set;
  logic [31:0] asm_word;
  logic        asm_full;

  loader_word_assembler u_asm (
    .clk       (CLK),
    .rst       (RESET),
    .clear     (start_load),
    .shift_in  (asm_shift),
    .byte_in   (byte_bus.BYTE_IN),
    .word_next (asm_word),
    .full      (asm_full)
  );

  assign byte_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
  assign xfer       = byte_ready && byte_bus.BYTE_VALID;
  assign hdr_len    = {byte_bus.BYTE_IN, len_lo_q};
  assign hdr_ok     = length_valid(hdr_len, ADDR_WIDTH);
  assign is_last    = (word_addr_q == last_addr_q);

  always_comb begin
    state_d      = state_q;
    start_load   = 1'b0;
    len_lo_load  = 1'b0;
    len_hi_load  = 1'b0;
    asm_shift    = 1'b0;
    word_capture = 1'b0;
    addr_incr    = 1'b0;
    done_set     = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (START) begin
          start_load = 1'b1;
          state_d    = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_lo_load = 1'b1;
          state_d     = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_hi_load = 1'b1;
          state_d     = hdr_ok ? ST_DATA : ST_ERROR;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          asm_shift = 1'b1;
          if (asm_full) begin
            word_capture = 1'b1;
            state_d      = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (is_last) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          addr_incr = 1'b1;
          state_d   = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= '0;
      last_addr_q <= '0;
      word_addr_q <= '0;
      address_q   <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_load)  done_q   <= 1'b0;
      if (done_set)    done_q   <= 1'b1;
      if (len_lo_load) len_lo_q <= byte_bus.BYTE_IN;
      if (len_hi_load) begin
        last_addr_q <= CNT_W'(hdr_len - 16'd1);
        word_addr_q <= '0;
      end
      // Write port registers load with the 4th byte so they are valid during WRITE and hold afterwards.
      if (word_capture) begin
        address_q <= word_addr_q[ADDR_WIDTH-1:0];
        data_q    <= asm_word;
      end
      if (addr_incr) word_addr_q <= word_addr_q + 1'b1;
    end
  end

  assign byte_bus.BYTE_READY = byte_ready;
  assign mem_bus.WRITE_ENABLE = (state_q == ST_WRITE);
  assign mem_bus.ADDRESS      = address_q;
  assign mem_bus.DATA_OUT     = data_q;
  assign BUSY  = byte_ready || (state_q == ST_WRITE);
  assign DONE  = done_q;
  assign ERROR = (state_q == ST_ERROR);

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: handshake, word assembly, length checks and reset abort.
module tb_rom_loader;

  logic CLK;
  logic RESET;
  logic START;
  logic BUSY, DONE, ERROR;

  rom_loader_byte_if byte_bus ();
  rom_loader_mem_if #(.ADDR_WIDTH(10)) mem_bus ();

  rom_loader #(.ADDR_WIDTH(10)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .byte_bus (byte_bus),
    .mem_bus  (mem_bus),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERROR    (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int xfer_cnt = 0;

  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          wr_xfer[$];

  always @(posedge CLK) cyc++;

  // Sampled just before each rising edge, when inputs and registered outputs are settled.
  always @(negedge CLK) begin
    #4;
    if (mem_bus.WRITE_ENABLE === 1'b1) begin
      wr_addr.push_back(mem_bus.ADDRESS);
      wr_data.push_back(mem_bus.DATA_OUT);
      wr_cyc.push_back(cyc);
      wr_xfer.push_back(xfer_cnt);
    end
    if (byte_bus.BYTE_VALID === 1'b1 && byte_bus.BYTE_READY === 1'b1) xfer_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_bus.BYTE_IN    = b;
    byte_bus.BYTE_VALID = 1'b1;
    while (byte_bus.BYTE_READY !== 1'b1 && t < 40) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 40) begin
      n_checks++;
      n_fail++;
      $error("FAIL ready_timeout: observed BYTE_READY low for %0d cycles expected high", t);
    end
    @(negedge CLK);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit toggle);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (toggle) begin
        byte_bus.BYTE_VALID = 1'b0;
        @(negedge CLK);
      end
    end
    byte_bus.BYTE_VALID = 1'b0;
  endtask

  initial begin
    logic [7:0]  s[$];
    logic [31:0] w;
    logic [15:0] iv;
    int base, base_x, bad;

    RESET = 1'b1;
    START = 1'b0;
    byte_bus.BYTE_IN    = 8'h00;
    byte_bus.BYTE_VALID = 1'b0;
    tick(3);
    RESET = 1'b0;

    // Idle with valid asserted and no START
    byte_bus.BYTE_VALID = 1'b1;
    byte_bus.BYTE_IN    = 8'h5A;
    tick(4);
    check("idle_ready", 32'(byte_bus.BYTE_READY), 32'd0);
    check("idle_we",    32'(mem_bus.WRITE_ENABLE), 32'd0);
    check("idle_addr",  32'(mem_bus.ADDRESS), 32'd0);
    check("idle_data",  mem_bus.DATA_OUT, 32'd0);
    check("idle_flags", {29'd0, BUSY, DONE, ERROR}, 32'd0);
    check("idle_nowr",  32'(wr_addr.size()), 32'd0);
    byte_bus.BYTE_VALID = 1'b0;
    tick(1);

    // Two-word back-to-back load
    base = wr_addr.size();
    pulse_start();
    check("start_ready", 32'(byte_bus.BYTE_READY), 32'd1);
    check("start_busy",  32'(BUSY), 32'd1);
    s = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_stream(s, 1'b0);
    tick(3);
    check("b2b_count", 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() - base == 2) begin
      check("b2b_addr0", 32'(wr_addr[base]),   32'd0);
      check("b2b_data0", wr_data[base],        32'h0000_0513);
      check("b2b_addr1", 32'(wr_addr[base+1]), 32'd1);
      check("b2b_data1", wr_data[base+1],      32'h0010_0593);
      check("b2b_gap",   32'(wr_cyc[base+1] - wr_cyc[base]), 32'd5);
    end
    check("b2b_done",  32'(DONE), 32'd1);
    check("b2b_busy",  32'(BUSY), 32'd0);
    check("b2b_hold_addr", 32'(mem_bus.ADDRESS), 32'd1);
    check("b2b_hold_data", mem_bus.DATA_OUT, 32'h0010_0593);

    // Zero-length header, then recovery with a one-word load
    base = wr_addr.size();
    pulse_start();
    check("start_clears_done", 32'(DONE), 32'd0);
    s = {8'h00, 8'h00};
    send_stream(s, 1'b0);
    tick(3);
    check("zero_error", 32'(ERROR), 32'd1);
    check("zero_busy",  32'(BUSY), 32'd0);
    check("zero_ready", 32'(byte_bus.BYTE_READY), 32'd0);
    check("zero_nowr",  32'(wr_addr.size() - base), 32'd0);
    pulse_start();
    check("restart_error_clr", 32'(ERROR), 32'd0);
    s = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream(s, 1'b0);
    tick(3);
    check("one_count", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base == 1) begin
      check("one_addr", 32'(wr_addr[base]), 32'd0);
      check("one_data", wr_data[base], 32'hDEAD_BEEF);
    end
    check("one_done", 32'(DONE), 32'd1);

    // Length just over and exactly at memory depth
    base = wr_addr.size();
    pulse_start();
    s = {8'h01, 8'h04};
    send_stream(s, 1'b0);
    tick(2);
    check("over_error", 32'(ERROR), 32'd1);
    check("over_nowr",  32'(wr_addr.size() - base), 32'd0);
    pulse_start();
    s = {8'h00, 8'h04};
    send_stream(s, 1'b0);
    check("full_hdr_ok", 32'(ERROR), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      iv = 16'(i);
      w  = {iv[7:0] ^ 8'h5A, 8'hC3, iv[15:8], iv[7:0]};
      s  = {w[7:0], w[15:8], w[23:16], w[31:24]};
      send_stream(s, 1'b0);
    end
    tick(3);
    check("full_count", 32'(wr_addr.size() - base), 32'd1024);
    bad = 0;
    if (wr_addr.size() - base == 1024) begin
      for (int i = 0; i < 1024; i++) begin
        iv = 16'(i);
        w  = {iv[7:0] ^ 8'h5A, 8'hC3, iv[15:8], iv[7:0]};
        if (wr_addr[base+i] !== iv[9:0] || wr_data[base+i] !== w) bad++;
      end
      check("full_last_addr", 32'(wr_addr[base+1023]), 32'd1023);
    end
    check("full_bad_words", 32'(bad), 32'd0);
    check("full_done", 32'(DONE), 32'd1);

    // Same two-word stream with BYTE_VALID toggling
    base   = wr_addr.size();
    base_x = xfer_cnt;
    pulse_start();
    s = {8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    send_stream(s, 1'b1);
    tick(3);
    check("tog_count", 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() - base == 2) begin
      check("tog_addr0", 32'(wr_addr[base]),   32'd0);
      check("tog_data0", wr_data[base],        32'h0000_0513);
      check("tog_addr1", 32'(wr_addr[base+1]), 32'd1);
      check("tog_data1", wr_data[base+1],      32'h0010_0593);
      check("tog_xfer0", 32'(wr_xfer[base]   - base_x), 32'd6);
      check("tog_xfer1", 32'(wr_xfer[base+1] - base_x), 32'd10);
      check("tog_gap",   32'(wr_cyc[base+1] - wr_cyc[base]), 32'd8);
    end
    check("tog_done", 32'(DONE), 32'd1);

    // Reset in the middle of word 0
    base = wr_addr.size();
    pulse_start();
    s = {8'h01, 8'h00, 8'hAA, 8'hBB};
    send_stream(s, 1'b0);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("rst_ready", 32'(byte_bus.BYTE_READY), 32'd0);
    check("rst_we",    32'(mem_bus.WRITE_ENABLE), 32'd0);
    check("rst_addr",  32'(mem_bus.ADDRESS), 32'd0);
    check("rst_data",  mem_bus.DATA_OUT, 32'd0);
    check("rst_flags", {29'd0, BUSY, DONE, ERROR}, 32'd0);
    tick(2);
    check("rst_nowr",  32'(wr_addr.size() - base), 32'd0);
    pulse_start();
    s = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(s, 1'b0);
    tick(3);
    check("post_rst_count", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base == 1) begin
      check("post_rst_addr", 32'(wr_addr[base]), 32'd0);
      check("post_rst_data", wr_data[base], 32'h4433_2211);
    end
    check("post_rst_done", 32'(DONE), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Program loader that fills the instruction memory read by `ROM`. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and issues one write per word to the instruction-memory write port at consecutive word addresses from 0. Sits between the host/debug byte source and instruction memory; `BUSY` is used to hold the core in reset while loading.

## Interface

- `ADDR_WIDTH`, 10, word-address width; memory depth is 2^ADDR_WIDTH words.

- `CLK`  in  1  clock, all logic on rising edge.
- `RESET`  in  1  synchronous, active-high.
- `START`  in  1  begin a load; sampled only in IDLE or ERROR.
- `BYTE_IN`  in  8  stream byte.
- `BYTE_VALID`  in  1  `BYTE_IN` valid.
- `BYTE_READY`  out  1  loader accepts a byte this cycle.
- `WRITE_ENABLE`  out  1  one-cycle memory write strobe.
- `ADDRESS`  out  ADDR_WIDTH  word address of the write.
- `DATA_OUT`  out  32  word written.
- `BUSY`  out  1  load in progress (LEN_LO through WRITE).
- `DONE`  out  1  last load completed; sticky until next START or RESET.
- `ERROR`  out  1  last length header invalid; sticky until next START or RESET.

## Operation

- Handshake: byte transferred on a cycle with `BYTE_VALID && BYTE_READY`. No transfer otherwise; the sender holds the byte.
- Stream format: 16-bit word count LENGTH (low byte, then high byte), then LENGTH×4 data bytes; first byte of each word → bits 7:0, fourth → bits 31:24.
- States:
  - IDLE: `BYTE_READY`=0. START → LEN_LO; clears DONE/ERROR.
  - LEN_LO: `BYTE_READY`=1; on transfer latch LENGTH[7:0] → LEN_HI.
  - LEN_HI: `BYTE_READY`=1; on transfer latch LENGTH[15:8]. If LENGTH==0 or LENGTH > 2^ADDR_WIDTH → ERROR; else → DATA with byte index 0, word address 0.
  - DATA: `BYTE_READY`=1; each transfer places the byte in lane `index` and increments the 2-bit index. Transfer at index 3 → WRITE.
  - WRITE: `BYTE_READY`=0, `WRITE_ENABLE`=1, `ADDRESS`=word address, `DATA_OUT`=assembled word. If word address == LENGTH−1 → IDLE and set DONE; else increment word address → DATA.
  - ERROR: `ERROR`=1, `BYTE_READY`=0. START → LEN_LO, clears ERROR.
- START outside IDLE/ERROR is ignored.
- Word counter is ADDR_WIDTH+1 bits so LENGTH = 2^ADDR_WIDTH compares without wrap; `ADDRESS` never wraps.
- `ADDRESS`/`DATA_OUT` hold their last values when `WRITE_ENABLE`=0.

## Timing

- All outputs reset to 0; state → IDLE; counters and assembly register cleared.
- RESET has priority over every other input, including mid-word or mid-write; the partial word is discarded, no further write issued, memory content left as-is.
- Write strobe asserted the cycle after the 4th byte transfer; exactly one cycle wide.
- Max throughput: 4 byte cycles + 1 write cycle = 5 cycles per word.
- DONE rises the cycle after the last write strobe; `BUSY` falls the same cycle.
- START in IDLE → `BYTE_READY`=1 on the next cycle.

## Structure

- Shared package: state encoding (IDLE, LEN_LO, LEN_HI, DATA, WRITE, ERROR), `BYTE_LANES`=4, header byte count=2.
- One sub-module: `loader_word_assembler` (lane index counter + 32-bit assembly register, clear/shift-in/full outputs). FSM, length check and address counter stay in `rom_loader`.

## Test plan

- Reset, then `BYTE_VALID`=1 without START → `BYTE_READY`=0, no write, all outputs 0.
- START; bytes 02 00 13 05 00 00 93 05 10 00 back-to-back → write ADDRESS 0 / DATA_OUT 0x00000513, then ADDRESS 1 / 0x00100593; 5 cycles apart; DONE=1, BUSY=0.
- Header 00 00 → ERROR=1, no write; START + valid 1-word load → ERROR clears, write to ADDRESS 0, DONE=1.
- ADDR_WIDTH=10, header 01 04 (1025) → ERROR=1; header 00 04 (1024) accepted, last write ADDRESS 1023.
- Same stream as scenario 2 with `BYTE_VALID` toggling every other cycle → identical words/addresses; strobe only after each 4th transfer.
- RESET after 2 data bytes of word 0 → outputs 0, IDLE, no write; new START load writes from ADDRESS 0 with fresh lanes (no stale bytes).
